// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-master memory bus arbiter.
//   - MNONE/MREAD/MWRITE bus command encodings and the 2-bit command type
//   - state_t: arbiter sequencer states
//   - is_req(): decodes a master command into "request pending" (2'b11 is idle)
package mem_arb_pkg;

  typedef logic [1:0] mcmd_t;

  localparam mcmd_t MNONE  = 2'b00;
  localparam mcmd_t MREAD  = 2'b01;
  localparam mcmd_t MWRITE = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp,
    StAck
  } state_t;

  function automatic logic is_req(input mcmd_t cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selector for the two-master arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin tie-breaking; when undefined,
// master 0 wins every tie and the last-winner input does not exist.
// Ports:
//   req   in  2  pending request per master (bit 0 = master 0)
//   last  in  1  last granted master (round-robin build only)
//   gnt   out 2  one-hot winner, 2'b00 when nothing is requested
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic       last,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
`ifdef MEM_ARB_RR_EN
    // On a tie the master that did not win last time goes next.
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
`else
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter and sequencer for the shared memory/MMIO bus.
// Grants one master in IDLE, latches its command, drives a single bus cycle,
// waits out the RAM's one-cycle read latency and returns data plus a one-cycle ack.
// Build option: MEM_ARB_RR_EN enables round-robin tie-breaking (else master 0 wins).
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   m0_cmd/m1_cmd                master commands (MNONE/MREAD/MWRITE, 2'b11 = none)
//   m0_addr/m1_addr, *_wdata     master address / write data
//   m0_rdata/m1_rdata, *_ack     registered read data and completion pulse
//   s_cmd, s_addr, s_wdata       bus command, address, write data
//   s_rdata                      bus read data, valid the cycle after MREAD
//   gnt                          one-hot current owner, 2'b00 when idle
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        m0_cmd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic [1:0]        m1_cmd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [1:0]        s_cmd,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        gnt
);

  state_t            state_q, state_d;
  mcmd_t             cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              win_q;      // 0 = master 0 owns the bus, 1 = master 1
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [1:0]        req, pick;
  logic              grant;

  assign req   = {is_req(m1_cmd), is_req(m0_cmd)};
  assign grant = (state_q == StIdle) && (pick != 2'b00);

`ifdef MEM_ARB_RR_EN
  logic last_q;  // last winner; resets to 1 so master 0 is favoured first

  mem_arb_pick u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (grant) begin
      last_q <= pick[1];
    end
  end
`else
  mem_arb_pick u_pick (
    .req (req),
    .gnt (pick)
  );
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick != 2'b00) state_d = StIssue;
      StIssue: state_d = (cmd_q == MREAD) ? StResp : StAck;
      StResp:  state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cmd_q    <= MNONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      win_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      // Master inputs are only looked at here; later changes are ignored.
      if (grant) begin
        win_q   <= pick[1];
        cmd_q   <= pick[1] ? m1_cmd   : m0_cmd;
        addr_q  <= pick[1] ? m1_addr  : m0_addr;
        wdata_q <= pick[1] ? m1_wdata : m0_wdata;
      end
      if (state_q == StResp) begin
        if (win_q) begin
          rdata1_q <= s_rdata;
        end else begin
          rdata0_q <= s_rdata;
        end
      end
    end
  end

  always_comb begin
    s_cmd    = (state_q == StIssue) ? cmd_q : MNONE;
    s_addr   = addr_q;
    s_wdata  = wdata_q;
    gnt      = (state_q == StIdle) ? 2'b00 : {win_q, ~win_q};
    m0_ack   = (state_q == StAck) && !win_q;
    m1_ack   = (state_q == StAck) && win_q;
    m0_rdata = rdata0_q;
    m1_rdata = rdata1_q;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter and sequencer for the shared 16-bit memory bus. It sits between the CPU (master 0) and a second bus master (master 1, e.g. a program loader or DMA engine) on one side, and the memory/MMIO bus on the other side (RAM plus switch/LED decode). It grants one master at a time and latches that master's command. It drives exactly one bus command cycle and absorbs the RAM's one-cycle synchronous read latency. It returns data and an acknowledge pulse to the granted master.

## Interface
- ADDR_W, 9: bus address width (bit 8 selects MMIO vs RAM downstream).
- DATA_W, 16: data width.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- m0_cmd, m1_cmd  in  2  request command per master: 2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE; 2'b11 is treated as MNONE.
- m0_addr, m1_addr  in  ADDR_W  request address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_rdata, m1_rdata  out  DATA_W  registered read data, valid while the matching ack is high.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- s_cmd  out  2  bus command (MNONE/MREAD/MWRITE).
- s_addr  out  ADDR_W  bus address.
- s_wdata  out  DATA_W  bus write data.
- s_rdata  in  DATA_W  bus read data; valid the cycle after an MREAD is driven.
- gnt  out  2  one-hot current owner; 2'b00 when idle.

## Operation
- Masters hold cmd/addr/wdata stable until they see ack, then drop cmd to MNONE or present a new request.
- States:
  - IDLE: s_cmd=MNONE, gnt=0. If any request is pending, pick a winner. Latch its cmd/addr/wdata into internal registers, set gnt, and go to ISSUE.
  - ISSUE: drive s_cmd/s_addr/s_wdata from the latched values for exactly one cycle. Next state is RESP on a read, ACK on a write.
  - RESP: s_cmd=MNONE, s_addr still held. Capture s_rdata into the winner's rdata register at the end of the cycle. Go to ACK.
  - ACK: assert the winner's ack for one cycle, keep gnt, s_cmd=MNONE. Go to IDLE and clear gnt.
- Master inputs are ignored outside IDLE. Mid-transaction changes have no effect.
- A master whose request is still present in IDLE after its ack is treated as a new request.
- Arbitration occurs only in IDLE. The loser keeps waiting with ack=0.
- rdata of the non-winning master is unchanged. rdata holds its last captured value until overwritten by a later read.

## Timing
- Request visible in IDLE before edge k: ISSUE is cycle k+1.
  - Read: RESP is k+2, ack is k+3.
  - Write: ack is k+2.
- Back-to-back throughput: read every 4 cycles, write every 3 cycles (one IDLE cycle always separates transactions).
- Reset values: state IDLE, gnt 2'b00, s_cmd MNONE, s_addr 0, s_wdata 0, m0/m1_ack 0, m0/m1_rdata 0, round-robin pointer favouring master 0.
- Reset asserted mid-transaction aborts it at the next edge: no ack is issued and no further bus command is driven. A write already driven in ISSUE is not undone.
- Simultaneous requests in IDLE resolve per Configuration.
- A write's ack follows the single MWRITE cycle. MMIO writes (e.g. the LED register at 0x100) rely on downstream capture in that cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer records the last winner. On simultaneous requests the other master wins.
  - The pointer updates only on grant.
- MEM_ARB_RR_EN undefined: fixed priority, master 0 always wins ties. The pointer logic is removed.

## Structure
- Package mem_arb_pkg: MNONE/MREAD/MWRITE command constants, the 2-bit command typedef, and the state enum (IDLE, ISSUE, RESP, ACK).
- One sub-module is natural: mem_arb_pick, the combinational winner selector (requests plus pointer in, one-hot grant out). It contains the MEM_ARB_RR_EN variation.
- The FSM, latches and rdata registers are built inline.

## Test plan
- Single read: m0 MREAD 0x005, RAM[5]=16'h1234 → s_cmd=MREAD in cycle k+1 only; m0_ack in k+3 with m0_rdata=16'h1234; m1_ack stays 0.
- Single write: m1 MWRITE 0x100 data 16'h00A5 → s_cmd=MWRITE, s_addr=0x100 in k+1; m1_ack in k+2; LEDR[7:0]=8'hA5 downstream.
- Simultaneous read requests, both held continuously:
  - With MEM_ARB_RR_EN: grants alternate m0, m1, m0 on acks at k+3, k+7, k+11.
  - Without it: m0 wins every time and m1 never acks.
- Mid-transaction input change: m0 reads 0x010, then switches addr to 0x020 during ISSUE → bus still shows 0x010; rdata is RAM[0x10].
- Reset in RESP: reset high one cycle → next cycle gnt=0, s_cmd=MNONE, no ack, rdata=0; a fresh read after reset completes normally.
- Illegal command: m0_cmd=2'b11 held 5 cycles → state stays IDLE, s_cmd=MNONE, no ack.
